// File: rtl/mmm_pkg.sv
`default_nettype none
// ============================================================================
// mmm_pkg : shared constants, state encoding and sizing helper for the MMM Rj
// Rev 1.0
// ============================================================================
package mmm_pkg;

    localparam int MMM_WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Rj needs two bits of headroom over the operand for R + a_i*B + q*M
    function automatic int mmm_reg_w(input int width);
        return width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmm_iter_cnt.sv
`default_nettype none
// ============================================================================
// mmm_iter_cnt : iteration counter, wraps after WIDTH-1, flags last iteration
// Rev 1.0
// ============================================================================
module mmm_iter_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mmm_rj_seq_reg.sv
`default_nettype none
// ============================================================================
// mmm_rj_seq_reg : Montgomery partial-result register with iteration sequencer
// Rev 1.0
// ============================================================================
module mmm_rj_seq_reg
    import mmm_pkg::*;
#(
    parameter int WIDTH = MMM_WIDTH_DEFAULT,
    parameter int REG_W = mmm_reg_w(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             rst_mmm_i,
    input  logic             start,
    input  logic             ld_a,
    input  logic [REG_W-1:0] rjo,
    input  logic [WIDTH-1:0] modulus,
    output logic [REG_W-1:0] reg_rji,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic             ge_mod
);

    logic [1:0]       r_state;
    logic [REG_W-1:0] r_rj;
    logic             r_busy;
    logic             r_done;
    logic             r_ge;

    logic [REG_W-1:0] w_shift;
    logic [REG_W-1:0] w_mod_ext;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_last;

    assign w_shift   = rjo >> 1;
    assign w_mod_ext = REG_W'(modulus);

    assign w_cnt_clr = !rst_mmm_i || (en && (r_state == ST_IDLE) && start);
    assign w_cnt_en  = rst_mmm_i && en && (r_state == ST_RUN) && !ld_a;

    mmm_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk  (clk),
        .rstb (rstb),
        .clr  (w_cnt_clr),
        .en   (w_cnt_en),
        .cnt  (bit_idx),
        .last (w_last)
    );

    // ge_mod is loaded on the edge into FIN so it is already valid alongside done
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_rj    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ge    <= 1'b0;
        end else if (!rst_mmm_i) begin
            r_state <= ST_IDLE;
            r_rj    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ge    <= 1'b0;
        end else if (!en) begin
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rj    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else if (ld_a) begin
                        r_rj    <= '0;
                    end
                end
                ST_RUN: begin
                    if (ld_a) begin
                        r_rj <= '0;
                    end else begin
                        r_rj <= w_shift;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ge    <= (w_shift >= w_mod_ext);
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    r_ge    <= (r_rj >= w_mod_ext);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign reg_rji = r_rj;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ge_mod  = r_ge;

endmodule
`default_nettype wire

// File: tb/tb_mmm_rj_seq_reg.sv
`default_nettype none
// ============================================================================
// tb_mmm_rj_seq_reg : directed self-checking bench, WIDTH=8 and WIDTH=16 copies
// Rev 1.0
// ============================================================================
module tb_mmm_rj_seq_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;

    logic        en_a, rmm_a, start_a, ld_a_a;
    logic [9:0]  rjo_a;
    logic [7:0]  mod_a;
    logic [9:0]  rj_a;
    logic [3:0]  idx_a;
    logic        busy_a, done_a, ge_a;

    logic        en_b, rmm_b, start_b, ld_a_b;
    logic [17:0] rjo_b;
    logic [15:0] mod_b;
    logic [17:0] rj_b;
    logic [4:0]  idx_b;
    logic        busy_b, done_b, ge_b;

    mmm_rj_seq_reg #(.WIDTH(8)) u_dut_a (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en_a),
        .rst_mmm_i (rmm_a),
        .start     (start_a),
        .ld_a      (ld_a_a),
        .rjo       (rjo_a),
        .modulus   (mod_a),
        .reg_rji   (rj_a),
        .bit_idx   (idx_a),
        .busy      (busy_a),
        .done      (done_a),
        .ge_mod    (ge_a)
    );

    mmm_rj_seq_reg #(.WIDTH(16)) u_dut_b (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en_b),
        .rst_mmm_i (rmm_b),
        .start     (start_b),
        .ld_a      (ld_a_b),
        .rjo       (rjo_b),
        .modulus   (mod_b),
        .reg_rji   (rj_b),
        .bit_idx   (idx_b),
        .busy      (busy_b),
        .done      (done_b),
        .ge_mod    (ge_b)
    );

    typedef struct packed {
        logic [17:0] rj;
        logic        ge;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   c0       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected final Rj is rjo>>1 of the last shift; ge is the unsigned compare
    task automatic start_run(input bit b, input logic [17:0] rjo_v);
        exp_t e;
        if (b) begin
            rjo_b   = rjo_v;
            e.rj    = rjo_v >> 1;
            e.ge    = (e.rj >= {2'b00, mod_b});
            start_b = 1'b1;
        end else begin
            rjo_a   = rjo_v[9:0];
            e.rj    = {9'b0, rjo_v[9:1]};
            e.ge    = (e.rj >= 18'(mod_a));
            start_a = 1'b1;
        end
        sb_q.push_back(e);
        c0 = cyc;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic finish_run(input bit b, input int exp_lat, input bit poke_start);
        exp_t e;
        while (!(b ? done_b : done_a) && (cyc - c0) < exp_lat + 8) tick();
        chk(b ? "done_seen_b" : "done_seen_a", b ? done_b : done_a, 1);
        chk(b ? "latency_b" : "latency_a", cyc - c0, exp_lat);
        chk(b ? "busy_in_fin_b" : "busy_in_fin_a", b ? busy_b : busy_a, 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(b ? "final_rj_b" : "final_rj_a", b ? rj_b : 18'(rj_a), e.rj);
            chk(b ? "final_ge_b" : "final_ge_a", b ? ge_b : ge_a, e.ge);
        end
        if (poke_start) begin
            if (b) start_b = 1'b1;
            else   start_a = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        chk(b ? "done_pulse_end_b" : "done_pulse_end_a", b ? done_b : done_a, 0);
        chk(b ? "busy_after_b" : "busy_after_a", b ? busy_b : busy_a, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rstb = 1'b0;
        en_a = 1'b1; rmm_a = 1'b1; start_a = 1'b0; ld_a_a = 1'b0; rjo_a = '0; mod_a = 8'hC5;
        en_b = 1'b1; rmm_b = 1'b1; start_b = 1'b0; ld_a_b = 1'b0; rjo_b = '0; mod_b = 16'h00C5;
        #1;
        chk("por_rj_a", rj_a, 0);
        chk("por_idx_a", idx_a, 0);
        chk("por_busy_a", busy_a, 0);
        chk("por_done_a", done_a, 0);
        chk("por_ge_a", ge_a, 0);
        chk("por_rj_b", rj_b, 0);
        repeat (2) tick();
        rstb = 1'b1;
        tick();

        // Full run, per-cycle view; start in the done cycle must be ignored
        start_run(0, 18'h3FF);
        for (int k = 0; k < 8; k++) begin
            chk("run_busy", busy_a, 1);
            chk("run_idx", idx_a, k);
            chk("run_rj", rj_a, (k == 0) ? 32'h0 : 32'h1FF);
            chk("run_done", done_a, 0);
            tick();
        end
        finish_run(0, 9, 1);
        tick();
        chk("fin_start_ignored", busy_a, 0);
        chk("ge_held_idle", ge_a, 1);

        // Asynchronous reset mid-run
        start_run(0, 18'h3FF);
        repeat (3) tick();
        chk("pre_rst_idx", idx_a, 3);
        rstb = 1'b0;
        #1;
        chk("arst_rj", rj_a, 0);
        chk("arst_idx", idx_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_ge", ge_a, 0);
        sb_q.delete();
        tick();
        rstb = 1'b1;
        start_run(0, 18'h188);
        finish_run(0, 9, 0);

        // Stall for three cycles at bit_idx 4
        start_run(0, 18'h3FF);
        repeat (4) tick();
        chk("pre_stall_idx", idx_a, 4);
        en_a = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_idx", idx_a, 4);
            chk("stall_rj", rj_a, 10'h1FF);
            chk("stall_busy", busy_a, 1);
        end
        en_a = 1'b1;
        finish_run(0, 12, 0);

        // Soft clear at bit_idx 5 aborts without a done pulse
        start_run(0, 18'h18A);
        repeat (5) tick();
        chk("pre_clr_idx", idx_a, 5);
        rmm_a = 1'b0;
        tick();
        rmm_a = 1'b1;
        chk("clr_rj", rj_a, 0);
        chk("clr_busy", busy_a, 0);
        chk("clr_idx", idx_a, 0);
        chk("clr_done", done_a, 0);
        sb_q.delete();
        seen = 0;
        repeat (10) begin
            tick();
            if (done_a) seen = 1;
        end
        chk("clr_no_done", seen, 0);
        start_run(0, 18'h18A);
        finish_run(0, 9, 0);

        // start and ld_a together in IDLE, then ld_a inside RUN
        ld_a_a = 1'b1;
        start_run(0, 18'h3FF);
        ld_a_a = 1'b0;
        chk("both_busy", busy_a, 1);
        chk("both_rj", rj_a, 0);
        chk("both_idx", idx_a, 0);
        repeat (2) tick();
        chk("pre_lda_idx", idx_a, 2);
        ld_a_a = 1'b1;
        tick();
        ld_a_a = 1'b0;
        chk("lda_run_rj", rj_a, 0);
        chk("lda_run_idx", idx_a, 2);
        tick();
        chk("lda_next_idx", idx_a, 3);
        chk("lda_next_rj", rj_a, 10'h1FF);
        finish_run(0, 10, 0);

        // ld_a alone in IDLE clears Rj only
        ld_a_a = 1'b1;
        tick();
        ld_a_a = 1'b0;
        chk("idle_lda_rj", rj_a, 0);
        chk("idle_lda_busy", busy_a, 0);
        chk("idle_lda_ge", ge_a, 1);

        // Compare boundary at WIDTH=8: equal, one below, largest reachable
        start_run(0, 18'h18A);
        finish_run(0, 9, 0);
        start_run(0, 18'h188);
        finish_run(0, 9, 0);
        start_run(0, 18'h3FF);
        finish_run(0, 9, 0);

        // Same boundaries at WIDTH=16
        chk("b_idle_busy", busy_b, 0);
        start_run(1, 18'h0018A);
        finish_run(1, 17, 0);
        start_run(1, 18'h00188);
        finish_run(1, 17, 0);
        start_run(1, 18'h3FFFF);
        finish_run(1, 17, 0);
        mod_b = 16'hFFFF;
        start_run(1, 18'h1FFFE);
        finish_run(1, 17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
